risc_controller: RTL and testbench

- Control sequencer for the 8-bit accumulator CPU (3-bit opcode, 5-bit address; opcodes HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7).
- Sits between the instruction register / accumulator-zero flag (upstream) and the datapath (PC, IR, ACC, memory, bus driver), which it drives downstream.
- Steps each instruction through 8 fixed phases and decodes phase plus opcode into datapath strobes.
- Generates the top-level `halt`.

---
 rtl/risc_controller.sv | 132 +++++++++++++
 tb/tb_risc_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_controller.sv
// Control sequencer for the 8-bit accumulator CPU.
// Steps every instruction through eight fixed phases and decodes
// (phase, opcode, zero, halted) into the datapath strobes.
module risc_controller #(
  parameter int PHASE_W = 3,
  parameter int OPC_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             stall,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             wr,
  output logic             data_e,
  output logic             halt
);

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR,
    INST_FETCH,
    INST_LOAD,
    IDLE,
    OP_ADDR,
    OP_FETCH,
    ALU_OP,
    STORE
  } phase_t;

  typedef enum logic [OPC_W-1:0] {
    OP_HLT,
    OP_SKZ,
    OP_ADD,
    OP_AND,
    OP_XOR,
    OP_LDA,
    OP_STO,
    OP_JMP
  } opc_t;

  phase_t phase;
  logic   halted;

  // Phase counter and halt latch; stall and halted freeze everything, rst wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= INST_ADDR;
      halted <= 1'b0;
    end else if (!stall && !halted) begin
      if (phase == OP_ADDR && opcode == OP_HLT) begin
        halted <= 1'b1;
      end else begin
        phase <= phase_t'(phase + 1'b1);
      end
    end
  end

  // Strobe decode; opcode is only consulted from OP_ADDR onward so an
  // unsettled IR during fetch cannot disturb sel/rd/ld_ir.
  always_comb begin
    logic aluop;
    logic is_jmp;
    logic is_sto;
    aluop  = 1'b0;
    is_jmp = 1'b0;
    is_sto = 1'b0;
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      case (phase)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        OP_FETCH: begin
          aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
          rd    = aluop;
        end
        ALU_OP: begin
          aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);
          rd     = aluop;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);
          is_jmp = (opcode == OP_JMP);
          is_sto = (opcode == OP_STO);
          rd     = aluop;
          ld_ac  = aluop;
          inc_pc = is_jmp;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc_controller.sv
// Directed bench for risc_controller. Outputs are packed as
// {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}.
module tb_risc_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       stall;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [8:0] vec;

  int n_checks;
  int n_fail;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDO = 3'd3,
                         XORO = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  localparam logic [8:0] V_P0   = 9'b100000000;
  localparam logic [8:0] V_P1   = 9'b110000000;
  localparam logic [8:0] V_P23  = 9'b111000000;
  localparam logic [8:0] V_P4   = 9'b000100000;
  localparam logic [8:0] V_P4H  = 9'b000100001;
  localparam logic [8:0] V_HALT = 9'b000000001;
  localparam logic [8:0] V_ZERO = 9'b000000000;

  risc_controller #(.PHASE_W(3), .OPC_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .stall  (stall),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt)
  );

  assign vec = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    opcode = HLT; zero = 1'b0; stall = 1'b0;
    rst = 1'b1;
    tick();
    n_checks++;
    if (vec !== V_P0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", vec, V_P0);
    end
    tick();
    n_checks++;
    if (vec !== V_P0) begin
      n_fail++;
      $display("FAIL reset_held: got %b expected %b", vec, V_P0);
    end
    rst = 1'b0;
    tick();
    tick();
    // phase 2, now reset together with stall
    stall = 1'b1;
    rst   = 1'b1;
    tick();
    n_checks++;
    if (vec !== V_P0) begin
      n_fail++;
      $display("FAIL reset_over_stall: got %b expected %b", vec, V_P0);
    end
    rst = 1'b0; stall = 1'b0;
  endtask

  task automatic test_halt();
    opcode = HLT; zero = 1'b1; stall = 1'b0;
    do_reset();
    tick();
    n_checks++;
    if (vec !== V_P1) begin
      n_fail++;
      $display("FAIL halt_phase1: got %b expected %b", vec, V_P1);
    end
    tick();
    tick();
    n_checks++;
    if (vec !== V_P23) begin
      n_fail++;
      $display("FAIL halt_phase3: got %b expected %b", vec, V_P23);
    end
    tick();
    n_checks++;
    if (vec !== V_P4H) begin
      n_fail++;
      $display("FAIL halt_phase4: got %b expected %b", vec, V_P4H);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (vec !== V_HALT) begin
        n_fail++;
        $display("FAIL halted_hold[%0d]: got %b expected %b", i, vec, V_HALT);
      end
    end
    // only reset leaves the halted state
    do_reset();
    n_checks++;
    if (vec !== V_P0) begin
      n_fail++;
      $display("FAIL halt_cleared: got %b expected %b", vec, V_P0);
    end
  endtask

  task automatic test_stall_hlt();
    opcode = HLT; zero = 1'b0; stall = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (vec !== V_P4H) begin
        n_fail++;
        $display("FAIL stall_hlt[%0d]: got %b expected %b", i, vec, V_P4H);
      end
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (vec !== V_HALT) begin
      n_fail++;
      $display("FAIL stall_hlt_release: got %b expected %b", vec, V_HALT);
    end
  endtask

  task automatic test_opcodes();
    logic [2:0] opc [7];
    logic       zv  [7];
    logic [8:0] e5  [7];
    logic [8:0] e6  [7];
    logic [8:0] e7  [7];
    logic [8:0] exp_v;
    opc[0] = JMP;  zv[0] = 1'b1; e5[0] = V_ZERO;       e6[0] = 9'b000010000; e7[0] = 9'b000110000;
    opc[1] = SKZ;  zv[1] = 1'b1; e5[1] = V_ZERO;       e6[1] = 9'b000100000; e7[1] = V_ZERO;
    opc[2] = SKZ;  zv[2] = 1'b0; e5[2] = V_ZERO;       e6[2] = V_ZERO;       e7[2] = V_ZERO;
    opc[3] = STO;  zv[3] = 1'b0; e5[3] = V_ZERO;       e6[3] = 9'b000000010; e7[3] = 9'b000000110;
    opc[4] = ADD;  zv[4] = 1'b0; e5[4] = 9'b010000000; e6[4] = 9'b010000000; e7[4] = 9'b010001000;
    opc[5] = ANDO; zv[5] = 1'b1; e5[5] = 9'b010000000; e6[5] = 9'b010000000; e7[5] = 9'b010001000;
    opc[6] = XORO; zv[6] = 1'b0; e5[6] = 9'b010000000; e6[6] = 9'b010000000; e7[6] = 9'b010001000;
    stall = 1'b0;
    for (int k = 0; k < 7; k++) begin
      opcode = opc[k]; zero = zv[k];
      do_reset();
      // two back-to-back instructions to cover the 7 -> 0 wrap
      for (int p = 0; p < 16; p++) begin
        case (p % 8)
          0:       exp_v = V_P0;
          1:       exp_v = V_P1;
          2, 3:    exp_v = V_P23;
          4:       exp_v = V_P4;
          5:       exp_v = e5[k];
          6:       exp_v = e6[k];
          default: exp_v = e7[k];
        endcase
        n_checks++;
        if (vec !== exp_v) begin
          n_fail++;
          $display("FAIL opcode%0d_z%0d_phase%0d: got %b expected %b",
                   opc[k], zv[k], p, vec, exp_v);
        end
        tick();
      end
    end
  endtask

  task automatic test_stall_fetch();
    opcode = ADD; zero = 1'b0; stall = 1'b0;
    do_reset();
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (vec !== V_P23) begin
        n_fail++;
        $display("FAIL stall_ld_ir[%0d]: got %b expected %b", i, vec, V_P23);
      end
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (vec !== V_P23) begin
      n_fail++;
      $display("FAIL stall_resume_p3: got %b expected %b", vec, V_P23);
    end
    tick();
    n_checks++;
    if (vec !== V_P4) begin
      n_fail++;
      $display("FAIL stall_resume_p4: got %b expected %b", vec, V_P4);
    end
    tick();
    // stall in phase 5 keeps the operand read asserted
    stall = 1'b1;
    tick();
    n_checks++;
    if (vec !== 9'b010000000) begin
      n_fail++;
      $display("FAIL stall_p5: got %b expected %b", vec, 9'b010000000);
    end
    stall = 1'b0;
    tick();
    tick();
    n_checks++;
    if (vec !== 9'b010001000) begin
      n_fail++;
      $display("FAIL stall_p7: got %b expected %b", vec, 9'b010001000);
    end
  endtask

  task automatic test_reset_mid();
    opcode = STO; zero = 1'b0; stall = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (vec !== 9'b000000010) begin
      n_fail++;
      $display("FAIL mid_phase6: got %b expected %b", vec, 9'b000000010);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (vec !== V_P0) begin
      n_fail++;
      $display("FAIL mid_reset_p0: got %b expected %b", vec, V_P0);
    end
    tick();
    n_checks++;
    if (vec !== V_P1) begin
      n_fail++;
      $display("FAIL mid_reset_p1: got %b expected %b", vec, V_P1);
    end
  endtask

  task automatic test_x_opcode();
    zero = 1'b0; stall = 1'b0;
    opcode = 3'bxxx;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      logic [2:0] exp3;
      exp3 = (p == 0) ? 3'b100 : (p == 1) ? 3'b110 : 3'b111;
      n_checks++;
      if (vec[8:6] !== exp3) begin
        n_fail++;
        $display("FAIL x_opcode_phase%0d: got %b expected %b", p, vec[8:6], exp3);
      end
      tick();
    end
    opcode = LDA;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; opcode = HLT; zero = 1'b0; stall = 1'b0;
    test_reset();
    test_halt();
    test_stall_hlt();
    test_opcodes();
    test_stall_fetch();
    test_reset_mid();
    test_x_opcode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
